// File: rtl/inst_mem_loadable.sv
// Synchronous-read instruction memory with fetch-fault detection and a streaming
// program loader; memory is cleared to FILL_WORD after every reset.
module inst_mem_loadable #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           Iaddr,
  input  logic                  fetch_en,
  output logic [DATA_WIDTH-1:0] Inst,
  output logic                  inst_valid,
  output logic                  inst_fault,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    CLEAR,
    READY,
    LOAD
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]     load_count_q, load_count_d;
  logic [DATA_WIDTH-1:0]   inst_q, inst_d;
  logic                    inst_valid_q, inst_valid_d;
  logic                    inst_fault_q, inst_fault_d;
  logic                    load_done_q, load_done_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic [ADDR_WIDTH-1:0]   fetch_idx;
  logic                    fetch_fault;
  logic                    ptr_at_end;
  logic                    load_accept;
  logic                    load_end;

  assign fetch_idx   = Iaddr[ADDR_WIDTH+1:2];
  assign fetch_fault = (Iaddr[1:0] != 2'b00) || (Iaddr[31:ADDR_WIDTH+2] != '0);
  assign ptr_at_end  = &ptr_q;
  assign load_accept = (state_q == LOAD) && load_valid;
  // A final word that is also the last slot yields one completion, not two.
  assign load_end    = load_accept && (load_last || ptr_at_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      load_count_q <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_fault_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_count_q <= load_count_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      inst_fault_q <= inst_fault_d;
      load_done_q  <= load_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (ptr_at_end) state_d = READY;
      READY:   if (load_start) state_d = LOAD;
      LOAD:    if (load_end)   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    inst_fault_d = 1'b0;
    load_done_d  = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = ptr_q;
    mem_wdata    = FILL_WORD;
    case (state_q)
      CLEAR: begin
        // ptr wraps back to zero as the clear finishes, ready for the first load.
        mem_we = 1'b1;
        ptr_d  = ptr_q + ADDR_WIDTH'(1);
      end
      READY: begin
        if (fetch_en) begin
          inst_valid_d = 1'b1;
          inst_fault_d = fetch_fault;
          inst_d       = fetch_fault ? FILL_WORD : mem[fetch_idx];
        end
        if (load_start) begin
          ptr_d        = '0;
          load_count_d = '0;
        end
      end
      LOAD: begin
        if (load_accept) begin
          mem_we       = 1'b1;
          mem_wdata    = load_data;
          ptr_d        = ptr_q + ADDR_WIDTH'(1);
          load_count_d = load_count_q + (ADDR_WIDTH+1)'(1);
          load_done_d  = load_end;
        end
      end
      default: ;
    endcase
  end

  assign Inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign inst_fault = inst_fault_q;
  assign load_ready = (state_q == LOAD);
  assign load_done  = load_done_q;
  assign load_count = load_count_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Randomised bench for inst_mem_loadable: a plain array mirrors memory contents and
// every fetch, load handshake and reset sequence is compared against it.
module tb_inst_mem_loadable;

  localparam int          AW    = 5;
  localparam int          DW    = 32;
  localparam int          DEPTH = 2 ** AW;
  localparam logic [31:0] FILL  = 32'h0000_0000;

  logic          clk;
  logic          rst;
  logic [31:0]   Iaddr;
  logic          fetch_en;
  logic [DW-1:0] Inst;
  logic          inst_valid;
  logic          inst_fault;
  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          load_done;
  logic [AW:0]   load_count;

  inst_mem_loadable #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FILL_WORD (FILL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Iaddr     (Iaddr),
    .fetch_en  (fetch_en),
    .Inst      (Inst),
    .inst_valid(inst_valid),
    .inst_fault(inst_fault),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .load_done (load_done),
    .load_count(load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_inst;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] a);
    if (ref_fault(a)) return FILL;
    return ref_mem[a / 4];
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0, 1:    a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      2:       a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      default: a = $urandom | 32'(DEPTH * 4);
    endcase
    return a;
  endfunction

  task automatic check_fetch(input string tag, input logic [31:0] a);
    checkOutput({tag, "_valid"}, 64'(inst_valid), 64'(1'b1));
    checkOutput({tag, "_fault"}, 64'(inst_fault), 64'(ref_fault(a)));
    checkOutput({tag, "_inst"}, 64'(Inst), 64'(ref_data(a)));
    ref_inst = ref_data(a);
  endtask

  task automatic check_idle(input string tag);
    checkOutput({tag, "_valid"}, 64'(inst_valid), 64'(1'b0));
    checkOutput({tag, "_hold"}, 64'(Inst), 64'(ref_inst));
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    fetch_en   = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    applyStimulus();
    checkOutput("rst_inst", 64'(Inst), 64'(0));
    checkOutput("rst_valid", 64'(inst_valid), 64'(0));
    checkOutput("rst_fault", 64'(inst_fault), 64'(0));
    checkOutput("rst_ready", 64'(load_ready), 64'(0));
    checkOutput("rst_done", 64'(load_done), 64'(0));
    checkOutput("rst_count", 64'(load_count), 64'(0));
    ref_inst = 32'h0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL;
    rst      = 1'b0;
    fetch_en = 1'b1;
    Iaddr    = 32'h7C;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus();
      checkOutput("clear_valid", 64'(inst_valid), 64'(0));
      checkOutput("clear_ready", 64'(load_ready), 64'(0));
    end
    applyStimulus();
    check_fetch("post_clear_fetch", 32'h7C);
    fetch_en = 1'b0;
  endtask

  task automatic load_program(input logic [31:0] words[$], input bit use_last, input int abort_at,
                              input bit start_fetch, input logic [31:0] start_addr);
    int n;
    n          = words.size();
    load_start = 1'b1;
    fetch_en   = start_fetch;
    Iaddr      = start_addr;
    applyStimulus();
    load_start = 1'b0;
    if (start_fetch) check_fetch("start_fetch", start_addr);
    else check_idle("start_idle");
    checkOutput("load_ready_rise", 64'(load_ready), 64'(1));
    checkOutput("load_count_zero", 64'(load_count), 64'(0));
    for (int i = 0; i < n; i++) begin
      if (abort_at == i) begin
        do_reset();
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        load_valid = 1'b0;
        fetch_en   = 1'($urandom);
        Iaddr      = rand_addr();
        applyStimulus();
        check_idle("load_gap");
        checkOutput("load_gap_ready", 64'(load_ready), 64'(1));
        checkOutput("load_gap_done", 64'(load_done), 64'(0));
      end
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = use_last && (i == n - 1);
      fetch_en   = 1'($urandom);
      Iaddr      = rand_addr();
      applyStimulus();
      ref_mem[i] = words[i];
      check_idle("load_fetch_ignored");
      checkOutput("load_count", 64'(load_count), 64'(i + 1));
      if (i < n - 1) begin
        checkOutput("load_done_early", 64'(load_done), 64'(0));
        checkOutput("load_ready_hold", 64'(load_ready), 64'(1));
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    checkOutput("load_done_pulse", 64'(load_done), 64'(1));
    checkOutput("load_ready_fall", 64'(load_ready), 64'(0));
    fetch_en = 1'b1;
    Iaddr    = 32'((n - 1) * 4);
    applyStimulus();
    check_fetch("fetch_after_load", 32'((n - 1) * 4));
    checkOutput("load_done_single", 64'(load_done), 64'(0));
    checkOutput("load_count_final", 64'(load_count), 64'(n));
    fetch_en = 1'b0;
  endtask

  task automatic fetch_random(input int cycles);
    logic [31:0] a;
    bit          en;
    repeat (cycles) begin
      en       = ($urandom_range(0, 3) != 0);
      a        = rand_addr();
      fetch_en = en;
      Iaddr    = a;
      applyStimulus();
      if (en) check_fetch("rand_fetch", a);
      else check_idle("rand_idle");
    end
    fetch_en = 1'b0;
  endtask

  function automatic void fill_random(ref logic [31:0] q[$], input int n);
    q.delete();
    repeat (n) q.push_back($urandom);
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected finish before it");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] words[$];
    logic [31:0] fixed_addrs[3];
    int          n;
    bit          use_last;

    Iaddr     = 32'h0;
    load_data = '0;
    do_reset();

    words = '{32'h0800_0005, 32'h3401_1234, 32'h3402_5678};
    load_program(words, 1'b1, -1, 1'b0, 32'h0);

    fetch_en = 1'b1;
    fixed_addrs = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      Iaddr = fixed_addrs[i];
      applyStimulus();
      check_fetch("b2b_fetch", fixed_addrs[i]);
    end
    fixed_addrs = '{32'h6, 32'h80, 32'h7C};
    for (int i = 0; i < 3; i++) begin
      Iaddr = fixed_addrs[i];
      applyStimulus();
      check_fetch("boundary_fetch", fixed_addrs[i]);
    end
    fetch_en = 1'b0;
    applyStimulus();
    check_idle("fetch_off");

    fill_random(words, DEPTH);
    load_program(words, 1'b0, -1, 1'b1, 32'h4);
    fetch_random(40);

    fill_random(words, DEPTH);
    load_program(words, 1'b1, -1, 1'b0, 32'h0);
    fetch_random(40);

    fill_random(words, DEPTH);
    load_program(words, 1'b0, 10, 1'b0, 32'h0);
    fetch_en = 1'b1;
    Iaddr    = 32'h0;
    applyStimulus();
    check_fetch("fetch_after_abort", 32'h0);
    checkOutput("count_after_abort", 64'(load_count), 64'(0));
    fetch_en = 1'b0;

    repeat (5) begin
      n        = $urandom_range(1, DEPTH);
      use_last = (n < DEPTH) ? 1'b1 : 1'($urandom);
      fill_random(words, n);
      load_program(words, use_last, -1, 1'($urandom), rand_addr());
      fetch_random(30);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_mem_loadable.md
# inst_mem_loadable

Parametrised, synchronous-read instruction memory for the exception/interrupt CPU, replacing the fixed 32-word combinational ROM. Fetches return one cycle after request. Misaligned or out-of-range fetch addresses are flagged so the CPU can raise an instruction-fetch exception. A streaming loader port lets the bench or a boot controller write a program into memory at run time, so no instructions are hard-coded. The block sits between the PC register and the decode stage.

## Interface
- ADDR_WIDTH, 5, word-address bits; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, instruction width
- FILL_WORD, 32'h0000_0000, value written by post-reset clear and returned on fault
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Iaddr  in  32  byte address of fetch
- fetch_en  in  1  fetch request this cycle
- Inst  out  DATA_WIDTH  registered instruction
- inst_valid  out  1  Inst/inst_fault valid this cycle
- inst_fault  out  1  fetch was misaligned or out of range
- load_start  in  1  begin program load at word 0
- load_valid  in  1  load_data present
- load_data  in  DATA_WIDTH  word to write
- load_last  in  1  qualifies final word (with load_valid)
- load_ready  out  1  loader may present a word
- load_done  out  1  one-cycle pulse when a load completes
- load_count  out  ADDR_WIDTH+1  words written by the current/last load

## Operation
- FSM states: CLEAR, READY, LOAD.
- CLEAR, entered on reset:
  - Writes FILL_WORD to word ptr, then ptr++.
  - After writing word DEPTH-1, goes to READY. Takes exactly DEPTH cycles.
- READY:
  - Fetches are served.
  - load_start=1 moves the FSM to LOAD with ptr=0 and load_count=0.
- LOAD:
  - load_ready=1 in this state only.
  - Each cycle with load_valid=1 writes load_data to mem[ptr], then ptr++ and load_count++.
  - The load ends on the accepted word that either carries load_last=1 or is at ptr=DEPTH-1. Both conditions together produce a single completion.
  - On completion: state goes to READY, load_done pulses for 1 cycle, load_count holds its final value.
  - Words not written keep their prior contents.
- Fetch index: Iaddr[ADDR_WIDTH+1:2].
- Fault: raised when Iaddr[1:0]!=0 or Iaddr[31:ADDR_WIDTH+2]!=0. A faulting fetch returns Inst=FILL_WORD with inst_fault=1; memory is not read.
- fetch_en outside READY:
  - Ignored.
  - inst_valid=0 the next cycle.
  - Inst holds its previous value.
- load_start outside READY is ignored. load_valid outside LOAD is ignored.

## Timing
- Reset values: Inst=0, inst_valid=0, inst_fault=0, load_ready=0, load_done=0, load_count=0, state=CLEAR, ptr=0.
- Fetch latency is 1 cycle. With fetch_en=1 at edge N in READY, Inst, inst_valid=1 and inst_fault are valid after edge N+1.
- Back-to-back fetches are allowed every cycle (throughput 1/cycle).
- fetch_en=0 gives inst_valid=0 the next cycle; Inst holds.
- fetch_en and load_start together in READY: the fetch is served (valid next cycle), and LOAD is entered next cycle.
- load_ready rises on the cycle after the load_start edge.
- load_done is asserted in the cycle after the final accepted word, together with the return to READY. The first fetch is possible in that same cycle.
- Reset mid-load or mid-clear:
  - Aborts the operation and returns all outputs to reset values.
  - Restarts CLEAR, so memory is fully re-cleared.
- A fetch of a word written in the immediately preceding LOAD cycle returns the new data (write completes before READY).

## Test plan
- Reset with DEPTH=32 -> load_ready=0 and inst_valid=0 for 32 cycles. Then fetch Iaddr=0x7C -> Inst=0x00000000, inst_fault=0.
- Load 3 words 0x08000005, 0x3401_1234, 0x3402_5678 with load_last on the third -> load_done pulses once, load_count=3. Then fetch 0x0, 0x4, 0x8 back-to-back -> those words on 3 consecutive cycles, inst_valid=1 each.
- Fetch Iaddr=0x6 -> inst_fault=1, Inst=0. Fetch Iaddr=0x80 (DEPTH=32) -> inst_fault=1. Fetch 0x7C -> inst_fault=0.
- Load 32 words with load_valid gaps and no load_last -> completes on the 32nd word, load_count=32, load_done pulses once. Repeat with load_last on word 32 -> single completion.
- Assert rst after 10 loaded words, then fetch 0x0 after CLEAR -> Inst=0 (memory cleared), load_count=0.
- fetch_en during LOAD -> inst_valid=0. Simultaneous fetch_en(0x4) and load_start in READY -> prior word at 0x4 returned, then load_ready=1.
